// File: rtl/serial_word_collector_if.sv
// Bundle between the serial bit source / word consumer and the collector.
// master drives bits and ready; slave returns the assembled word and status.
interface serial_word_collector_if #(parameter int WIDTH = 8);
   localparam int CW = $clog2(WIDTH) + 1;

   logic             in;
   logic             bit_en;
   logic             start;
   logic             ready;
   logic [WIDTH-1:0] word;
   logic             valid;
   logic             overrun;
   logic [CW-1:0]    count;

   modport master (output in, bit_en, start, ready,
                   input  word, valid, overrun, count);
   modport slave  (input  in, bit_en, start, ready,
                   output word, valid, overrun, count);
endinterface

// File: rtl/serial_word_collector.sv
// Assembles LSB-first serial bits into WIDTH-bit words held for a valid/ready consumer.
// Word appears on the final bit's edge; a completed word is dropped (sticky overrun) while the holder is full and not read.
module serial_word_collector #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 reset,
   serial_word_collector_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int IW = $clog2(WIDTH);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

   out_state_t       state;
   out_state_t       state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [WIDTH-1:0] assembled;
   logic [WIDTH-1:0] word_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_nxt;
   logic [IW-1:0]    pos;
   logic             complete;
   logic             load;
   logic             drop;
   logic             overrun_q;

   // A start bit always lands at position 0 and throws away the partial word.
   always_comb begin
      pos       = bus.start ? '0 : count_q[IW-1:0];
      assembled = bus.start ? '0 : shreg;
      assembled[pos] = bus.in;
      complete  = bus.bit_en && (pos == IW'(WIDTH - 1));
      load      = complete && ((state == EMPTY) || bus.ready);
      drop      = complete && (state == FULL) && !bus.ready;
   end

   always_comb begin
      count_nxt = count_q;
      shreg_nxt = shreg;
      if (bus.bit_en) begin
         shreg_nxt = complete ? '0 : assembled;
         count_nxt = complete ? '0 : CW'(pos) + CW'(1);
      end else if (bus.start) begin
         count_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (complete) state_nxt = FULL;
         FULL:    if (!complete && bus.ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg     <= '0;
         count_q   <= '0;
         word_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         shreg   <= shreg_nxt;
         count_q <= count_nxt;
         if (load) word_q <= assembled;
         if (drop) overrun_q <= 1'b1;
      end
   end

   assign bus.valid   = (state == FULL);
   assign bus.word    = word_q;
   assign bus.overrun = overrun_q;
   assign bus.count   = count_q;
endmodule

// File: doc/serial_word_collector.md
SERIAL_WORD_COLLECTOR -- requirements
Module: serial_word_collector

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per word; legal range 2..32.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 in  input  1  serial data bit, LSB-first, from the upstream two's-complement converter output.
REQ-005 bit_en  input  1  qualifies in; a bit is accepted only on an edge where bit_en=1.
REQ-006 start  input  1  marks the accepted bit as bit 0 of a new word; aborts any partial word.
REQ-007 ready  input  1  downstream accepts word on an edge where valid=1 and ready=1.
REQ-008 word  output  WIDTH  assembled word; bit i equals the i-th accepted bit of the frame.
REQ-009 valid  output  1  word holds an unconsumed completed word.
REQ-010 overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 count  output  log2(WIDTH)+1  number of bits accepted in the current partial word.

Function
REQ-012 Collect side: shift register plus bit counter 0..WIDTH-1; output side: holding register word plus valid flag (states EMPTY / FULL).
REQ-013 Accepted bit with start=0 is written at position count; count increments.
REQ-014 Accepted bit with start=1 is written at position 0; count becomes 1; prior partial bits are discarded.
REQ-015 start=1 with bit_en=0: count clears to 0; no bit is written.
REQ-016 Accepting the bit at position WIDTH-1 completes the word; count returns to 0 on that edge.
REQ-017 On completion with the output EMPTY: word loads the full assembled value, and valid rises on the same edge, giving a latency of 0 cycles after the final bit's edge.
REQ-018 On completion while FULL and ready=1 on the same edge: the old word is consumed, the new word loads, and valid stays 1.
REQ-019 On completion while FULL and ready=0: the new word is dropped, word and valid are unchanged, and overrun is set to 1.
REQ-020 With valid=1 and ready=1 and no completion, valid clears on that edge; word retains its last value.
REQ-021 ready has no effect while valid=0.
REQ-022 overrun clears only on reset.
REQ-023 word, valid and overrun are driven directly from registers.
REQ-024 bit_en=0 with start=0: all state holds.

Reset
REQ-025 While reset=1, the block holds: word=0, valid=0, overrun=0, count=0, and the shift register at 0.
REQ-026 Reset asserted mid-word discards the partial bits; the first accepted bit after release is bit 0, regardless of start.
REQ-027 Reset asserted while valid=1 discards the held word without any handshake.

Verification (WIDTH=8)
REQ-028 Reset, then start=1 on the first bit, then bits 0,0,1,1,0,1,0,0 on consecutive edges with ready=0 -> word=0x2C and valid=1 after the 8th edge, with overrun=0.
REQ-029 Continuing from REQ-028, ready=1 for one edge -> valid=0 and word still 0x2C; then eight bits of 1 -> word=0xFF and valid=1.
REQ-030 Back-to-back frames 0x01 then 0x80, with ready=0 throughout -> word=0x01, valid=1, overrun=1 after the 16th bit.
REQ-031 Same back-to-back frames with ready=1 on the edge of the 16th bit -> word=0x80, valid=1, overrun=0.
REQ-032 Five bits accepted, then start=1 with bits 1,0,0,0,0,0,0,0 -> word=0x01; the partial bits do not appear in word.
REQ-033 Reset pulsed asynchronously between edges after 3 bits -> outputs are 0 immediately, count=0, and the next eight bits form a fresh word.
